gpio_sel_sequencer: RTL and testbench

//  Parametrised, registered successor to the combinational GPIO select decoder.

---
 rtl/gpio_sel_pkg.sv | 13 +
 rtl/gpio_onehot_dec.sv | 22 ++
 rtl/gpio_sel_sequencer.sv | 119 +++++++++++
 tb/tb_gpio_sel_sequencer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/gpio_sel_pkg.sv
// Shared types and constants for the GPIO select sequencer and its decoder.
package gpio_sel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEVEL = 2'd1,
        PULSE = 2'd2
    } gpio_sel_state_t;

    localparam logic MODE_LEVEL = 1'b0;
    localparam logic MODE_PULSE = 1'b1;

endpackage

// File: rtl/gpio_onehot_dec.sv
// Combinational 1-based index to one-hot decoder with in-range flag.
module gpio_onehot_dec #(
    parameter int NUM_GPIO = 34,
    parameter int SEL_W    = $clog2(NUM_GPIO + 1)
) (
    input  logic [SEL_W-1:0]    sel,
    output logic [NUM_GPIO-1:0] onehot,
    output logic                in_range
);

    // Each bit compares the full-width index, so 0 and every value above
    // NUM_GPIO (including the all-ones index) decode to an all-zero vector.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_GPIO; gi++) begin : g_bit
            assign onehot[gi] = (sel == SEL_W'(gi + 1));
        end
    endgenerate

    assign in_range = |onehot;

endmodule

// File: rtl/gpio_sel_sequencer.sv
// Registered one-hot GPIO strobe sequencer with level and timed-pulse modes.
// Optional error counter output enabled by defining GPIO_SEL_SEQ_ERRCNT_EN.
module gpio_sel_sequencer
    import gpio_sel_pkg::*;
#(
    parameter int NUM_GPIO = 34,
    parameter int SEL_W    = $clog2(NUM_GPIO + 1),
    parameter int PULSE_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sel_valid,
    input  logic [SEL_W-1:0]    sel,
    input  logic                mode,
    input  logic [PULSE_W-1:0]  pulse_len,
    output logic                sel_ready,
    output logic [NUM_GPIO-1:0] gpio_out,
    output logic                busy,
    output logic                sel_err
`ifdef GPIO_SEL_SEQ_ERRCNT_EN
    ,
    output logic [7:0]          err_count
`endif
);

    gpio_sel_state_t     state_reg, state_next;
    logic [NUM_GPIO-1:0] gpio_reg, gpio_next;
    logic [PULSE_W-1:0]  cnt_reg, cnt_next;
    logic                err_reg, err_next;

    logic [NUM_GPIO-1:0] dec_onehot;
    logic                dec_in_range;
    logic                accept;

    gpio_onehot_dec #(
        .NUM_GPIO (NUM_GPIO),
        .SEL_W    (SEL_W)
    ) u_dec (
        .sel      (sel),
        .onehot   (dec_onehot),
        .in_range (dec_in_range)
    );

    assign sel_ready = (state_reg != PULSE);
    assign busy      = (state_reg == PULSE);
    assign accept    = sel_valid & sel_ready;
    assign gpio_out  = gpio_reg;
    assign sel_err   = err_reg;

    always_comb begin
        state_next = state_reg;
        gpio_next  = gpio_reg;
        cnt_next   = cnt_reg;
        err_next   = 1'b0;
        case (state_reg)
            IDLE, LEVEL: begin
                if (accept) begin
                    if (dec_in_range) begin
                        gpio_next = dec_onehot;
                        if (mode == MODE_PULSE) begin
                            state_next = PULSE;
                            // Counter holds remaining cycles after the first; a zero length acts as one.
                            cnt_next   = (pulse_len == '0) ? '0 : pulse_len - PULSE_W'(1);
                        end else begin
                            state_next = LEVEL;
                        end
                    end else begin
                        state_next = IDLE;
                        gpio_next  = '0;
                        err_next   = 1'b1;
                    end
                end
            end
            PULSE: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - PULSE_W'(1);
                end else begin
                    state_next = IDLE;
                    gpio_next  = '0;
                end
            end
            default: begin
                state_next = IDLE;
                gpio_next  = '0;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            gpio_reg  <= '0;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            gpio_reg  <= gpio_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
        end
    end

`ifdef GPIO_SEL_SEQ_ERRCNT_EN
    logic [7:0] errcnt_reg;

    // Saturating count of accepted out-of-range commands.
    always_ff @(posedge clk) begin
        if (rst) begin
            errcnt_reg <= '0;
        end else if (accept && !dec_in_range && errcnt_reg != 8'hFF) begin
            errcnt_reg <= errcnt_reg + 8'd1;
        end
    end

    assign err_count = errcnt_reg;
`endif

endmodule

// File: tb/tb_gpio_sel_sequencer.sv
// Self-checking bench for gpio_sel_sequencer: directed vector table plus multi-cycle sequences.
module tb_gpio_sel_sequencer;

    localparam int NUM_GPIO = 34;
    localparam int SEL_W    = 6;
    localparam int PULSE_W  = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                sel_valid;
    logic [SEL_W-1:0]    sel;
    logic                mode;
    logic [PULSE_W-1:0]  pulse_len;
    logic                sel_ready;
    logic [NUM_GPIO-1:0] gpio_out;
    logic                busy;
    logic                sel_err;
`ifdef GPIO_SEL_SEQ_ERRCNT_EN
    logic [7:0]          err_count;
`endif

    gpio_sel_sequencer #(
        .NUM_GPIO (NUM_GPIO),
        .SEL_W    (SEL_W),
        .PULSE_W  (PULSE_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sel_valid (sel_valid),
        .sel       (sel),
        .mode      (mode),
        .pulse_len (pulse_len),
        .sel_ready (sel_ready),
        .gpio_out  (gpio_out),
        .busy      (busy),
        .sel_err   (sel_err)
`ifdef GPIO_SEL_SEQ_ERRCNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic                rst;
        logic                valid;
        logic [SEL_W-1:0]    sel;
        logic                mode;
        logic [PULSE_W-1:0]  len;
        logic [NUM_GPIO-1:0] gpio;
        logic                busy;
        logic                ready;
        logic                err;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply inputs on the falling edge, then return at the next falling edge
    // so the outputs reflect exactly one rising edge.
    task automatic step(input logic r, input logic v, input logic [SEL_W-1:0] s,
                        input logic m, input logic [PULSE_W-1:0] l);
        rst       = r;
        sel_valid = v;
        sel       = s;
        mode      = m;
        pulse_len = l;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 6'd0, 1'b0, 8'd0);
    endtask

    initial begin
        logic [NUM_GPIO-1:0] exp_vec;
        int                  exp_w;
        logic [PULSE_W-1:0]  rlen;

        // Columns: rst valid sel mode len | gpio busy ready err
        vecs[0]  = '{1'b1, 1'b0, 6'd0,  1'b0, 8'd0, 34'h0,           1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 6'd1,  1'b0, 8'd0, 34'h1,           1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 6'd0,  1'b0, 8'd0, 34'h1,           1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 6'd34, 1'b0, 8'd0, 34'h2_0000_0000, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 6'd5,  1'b1, 8'd3, 34'h10,          1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 6'd7,  1'b0, 8'd0, 34'h10,          1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 6'd0,  1'b0, 8'd0, 34'h10,          1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 6'd0,  1'b0, 8'd0, 34'h0,           1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 6'd2,  1'b1, 8'd0, 34'h2,           1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 6'd3,  1'b0, 8'd0, 34'h0,           1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 6'd3,  1'b0, 8'd0, 34'h4,           1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 6'd0,  1'b0, 8'd0, 34'h0,           1'b0, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 6'd0,  1'b0, 8'd0, 34'h0,           1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 6'd40, 1'b0, 8'd0, 34'h0,           1'b0, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 6'd63, 1'b1, 8'd5, 34'h0,           1'b0, 1'b1, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 6'd6,  1'b0, 8'd0, 34'h20,          1'b0, 1'b1, 1'b0};
        vecs[16] = '{1'b1, 1'b1, 6'd9,  1'b0, 8'd0, 34'h0,           1'b0, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 6'd33, 1'b1, 8'd1, 34'h1_0000_0000, 1'b1, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 6'd0,  1'b0, 8'd0, 34'h0,           1'b0, 1'b1, 1'b0};

        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].rst, vecs[i].valid, vecs[i].sel, vecs[i].mode, vecs[i].len);
            $display("vec %0d: rst=%0b valid=%0b sel=%0d mode=%0b len=%0d -> gpio=%0h busy=%0b ready=%0b err=%0b",
                     i, vecs[i].rst, vecs[i].valid, vecs[i].sel, vecs[i].mode, vecs[i].len,
                     gpio_out, busy, sel_ready, sel_err);
            chk($sformatf("vec%0d_gpio", i),  64'(gpio_out),  64'(vecs[i].gpio));
            chk($sformatf("vec%0d_busy", i),  64'(busy),      64'(vecs[i].busy));
            chk($sformatf("vec%0d_ready", i), 64'(sel_ready), 64'(vecs[i].ready));
            chk($sformatf("vec%0d_err", i),   64'(sel_err),   64'(vecs[i].err));
        end

        // Level vector held indefinitely without further commands.
        step(1'b0, 1'b1, 6'd1, 1'b0, 8'd0);
        for (int c = 0; c < 20; c++) begin
            idle();
            chk($sformatf("level_hold_c%0d", c), 64'(gpio_out), 64'h1);
        end
        $display("level hold: sel=1 held 20 cycles gpio=%0h", gpio_out);

        // Reset in the middle of a long pulse.
        step(1'b0, 1'b1, 6'd10, 1'b1, 8'd200);
        for (int c = 1; c < 50; c++) begin
            idle();
            chk($sformatf("long_pulse_c%0d", c), 64'({busy, gpio_out}), 64'({1'b1, 34'h200}));
        end
        step(1'b1, 1'b0, 6'd0, 1'b0, 8'd0);
        $display("reset mid-pulse: gpio=%0h busy=%0b ready=%0b", gpio_out, busy, sel_ready);
        chk("rst_mid_gpio",  64'(gpio_out),  64'h0);
        chk("rst_mid_busy",  64'(busy),      64'h0);
        chk("rst_mid_ready", 64'(sel_ready), 64'h1);

`ifdef GPIO_SEL_SEQ_ERRCNT_EN
        chk("errcnt_after_rst", 64'(err_count), 64'h0);
        step(1'b0, 1'b1, 6'd0, 1'b0, 8'd0);
        step(1'b0, 1'b1, 6'd40, 1'b0, 8'd0);
        idle();
        $display("err_count after two errors: %0d", err_count);
        chk("errcnt_two", 64'(err_count), 64'd2);
        for (int k = 0; k < 298; k++) begin
            step(1'b0, 1'b1, 6'd50, 1'b0, 8'd0);
        end
        idle();
        $display("err_count after 300 errors: %0d", err_count);
        chk("errcnt_sat", 64'(err_count), 64'd255);
`endif

        // Sweep every index in both modes.
        step(1'b0, 1'b0, 6'd0, 1'b0, 8'd0);
        for (int s = 1; s <= NUM_GPIO; s++) begin
            exp_vec = 34'h1 << (s - 1);
            step(1'b0, 1'b1, 6'(s), 1'b0, 8'd0);
            chk($sformatf("sweep_lvl%0d", s), 64'(gpio_out), 64'(exp_vec));
            chk($sformatf("sweep_lvl%0d_1hot", s), 64'($onehot0(gpio_out)), 64'h1);

            rlen  = 8'($urandom_range(0, 6));
            exp_w = (rlen == 8'd0) ? 1 : int'(rlen);
            step(1'b0, 1'b1, 6'(s), 1'b1, rlen);
            for (int k = 0; k <= exp_w; k++) begin
                if (k < exp_w) begin
                    chk($sformatf("sweep_pls%0d_k%0d", s, k), 64'({busy, gpio_out}), 64'({1'b1, exp_vec}));
                end else begin
                    chk($sformatf("sweep_pls%0d_end", s), 64'({busy, gpio_out}), 64'h0);
                end
                chk($sformatf("sweep_pls%0d_1hot", s), 64'($onehot0(gpio_out)), 64'h1);
                idle();
            end
            $display("sweep sel=%0d len=%0d width=%0d done", s, rlen, exp_w);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
